stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 18 +
 rtl/stack_ram.sv | 31 +++
 rtl/stack_unit.sv | 170 +++++++++++++++++
 tb/tb_stack_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared op-code constants and FSM state type for the stack unit.
package stack_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_BINOP = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_REPL  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic {
    ST_READY  = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Backing store for stack elements below NOS: one write port, one synchronous read port.
module stack_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ENTRIES    = 14,
  parameter int unsigned ADDR_WIDTH = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port and registered read port; no reset, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/stack_unit.sv
// Register-cached stack: TOS/NOS in flops, deeper elements spilled to stack_ram.
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  general_clk,
  input  logic                  general_reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] tos_out,
  output logic [DATA_WIDTH-1:0] nos_out,
  output logic [PTR_WIDTH-1:0]  depth_out,
  output logic                  empty,
  output logic                  full,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  err_clear
);

  localparam int unsigned RAM_ENTRIES = DEPTH - 2;
  localparam int unsigned AW          = $clog2(RAM_ENTRIES);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tos_q, tos_d;
  logic [DATA_WIDTH-1:0] nos_q, nos_d;
  logic [PTR_WIDTH-1:0]  depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  ram_wr_en, ram_rd_en;
  logic [AW-1:0]         ram_wr_addr, ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  logic is_empty, is_full, ge2, ge3;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == PTR_WIDTH'(DEPTH));
  assign ge2      = (depth_q >= PTR_WIDTH'(2));
  assign ge3      = (depth_q >= PTR_WIDTH'(3));

  // RAM address = bottom-relative index: old NOS spills to depth-2, new NOS refills from depth-3.
  assign ram_wr_addr = AW'(depth_q - PTR_WIDTH'(2));
  assign ram_rd_addr = AW'(depth_q - PTR_WIDTH'(3));

  stack_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (RAM_ENTRIES),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (general_clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (nos_q),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Next-state, stack update, spill/refill control and sticky error flags.
  always_comb begin
    state_d   = state_q;
    tos_d     = tos_q;
    nos_d     = nos_q;
    depth_d   = depth_q;
    ovf_d     = err_clear ? 1'b0 : ovf_q;
    unf_d     = err_clear ? 1'b0 : unf_q;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    case (state_q)
      ST_REFILL: begin
        nos_d   = ram_rd_data;
        state_d = ST_READY;
      end
      default: begin
        if (op_valid) begin
          case (op_code)
            OP_PUSH: begin
              if (is_full) begin
                ovf_d = 1'b1;
              end else begin
                tos_d     = push_data;
                nos_d     = tos_q;
                ram_wr_en = ge2;
                depth_d   = depth_q + PTR_WIDTH'(1);
              end
            end
            OP_POP: begin
              if (is_empty) begin
                unf_d = 1'b1;
              end else begin
                tos_d     = nos_q;
                depth_d   = depth_q - PTR_WIDTH'(1);
                ram_rd_en = ge3;
                if (ge3) state_d = ST_REFILL;
              end
            end
            OP_BINOP: begin
              if (!ge2) begin
                unf_d = 1'b1;
              end else begin
                tos_d     = push_data;
                depth_d   = depth_q - PTR_WIDTH'(1);
                ram_rd_en = ge3;
                if (ge3) state_d = ST_REFILL;
              end
            end
            OP_DUP: begin
              if (is_empty) begin
                unf_d = 1'b1;
              end else if (is_full) begin
                ovf_d = 1'b1;
              end else begin
                nos_d     = tos_q;
                ram_wr_en = ge2;
                depth_d   = depth_q + PTR_WIDTH'(1);
              end
            end
            OP_SWAP: begin
              if (!ge2) begin
                unf_d = 1'b1;
              end else begin
                tos_d = nos_q;
                nos_d = tos_q;
              end
            end
            OP_REPL: begin
              if (is_empty) unf_d = 1'b1;
              else          tos_d = push_data;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State register; reset aborts any pending refill.
  always_ff @(posedge general_clk or posedge general_reset) begin
    if (general_reset) begin
      state_q <= ST_READY;
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign op_ready      = !general_reset && (state_q == ST_READY);
  assign tos_out       = is_empty ? '0 : tos_q;
  assign nos_out       = ge2 ? nos_q : '0;
  assign depth_out     = depth_q;
  assign empty         = is_empty;
  assign full          = is_full;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (DATA_WIDTH=8, DEPTH=4).
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op_code = 3'd0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] tos_out, nos_out;
  logic [2:0] depth_out;
  logic       empty, full, err_overflow, err_underflow;
  logic       err_clear = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_unit #(
    .DATA_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .general_clk   (clk),
    .general_reset (rst),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_code       (op_code),
    .push_data     (push_data),
    .tos_out       (tos_out),
    .nos_out       (nos_out),
    .depth_out     (depth_out),
    .empty         (empty),
    .full          (full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_clear     (err_clear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] c, input logic [7:0] d, input logic clr);
    op_valid  = 1'b1;
    op_code   = c;
    push_data = d;
    err_clear = clr;
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    op_code   = 3'd0;
    err_clear = 1'b0;
  endtask

  task automatic idle(input logic clr);
    err_clear = clr;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
  endtask

  task automatic chk_stack(input string tag, input logic [7:0] t, input logic [7:0] n,
                           input logic [2:0] d);
    chk({tag, "_tos"},   32'(tos_out),   32'(t));
    chk({tag, "_nos"},   32'(nos_out),   32'(n));
    chk({tag, "_depth"}, 32'(depth_out), 32'(d));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_depth", 32'(depth_out), 32'd0);
    chk("rst_tos", 32'(tos_out), 32'd0);
    chk("rst_nos", 32'(nos_out), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(err_overflow), 32'd0);
    chk("rst_unf", 32'(err_underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;

    // Three pushes back to back
    op(3'd1, 8'h11, 1'b0);
    chk("push1_ready", 32'(op_ready), 32'd1);
    op(3'd1, 8'h22, 1'b0);
    chk("push2_ready", 32'(op_ready), 32'd1);
    op(3'd1, 8'h33, 1'b0);
    chk("push3_ready", 32'(op_ready), 32'd1);
    chk_stack("push3", 8'h33, 8'h22, 3'd3);

    // Pop with refill
    op(3'd2, 8'h00, 1'b0);
    chk("pop_tos", 32'(tos_out), 32'h22);
    chk("pop_depth", 32'(depth_out), 32'd2);
    chk("pop_ready_refill", 32'(op_ready), 32'd0);
    idle(1'b0);
    chk("pop_ready_after", 32'(op_ready), 32'd1);
    chk_stack("pop_refilled", 8'h22, 8'h11, 3'd2);

    // Fill, overflow, clear
    op(3'd1, 8'h33, 1'b0);
    op(3'd1, 8'h44, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    op(3'd1, 8'h55, 1'b0);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk_stack("ovf", 8'h44, 8'h33, 3'd4);
    idle(1'b1);
    chk("ovf_clear", 32'(err_overflow), 32'd0);

    // Drain to confirm spilled contents
    op(3'd2, 8'h00, 1'b0);
    idle(1'b0);
    chk_stack("drain1", 8'h33, 8'h22, 3'd3);
    op(3'd2, 8'h00, 1'b0);
    idle(1'b0);
    chk_stack("drain2", 8'h22, 8'h11, 3'd2);
    op(3'd2, 8'h00, 1'b0);
    chk("drain3_ready", 32'(op_ready), 32'd1);
    chk_stack("drain3", 8'h11, 8'h00, 3'd1);
    op(3'd2, 8'h00, 1'b0);
    chk_stack("drain4", 8'h00, 8'h00, 3'd0);
    chk("drain4_empty", 32'(empty), 32'd1);

    // Underflow, sticky, clear racing a new error
    op(3'd2, 8'h00, 1'b0);
    chk("unf_pop_flag", 32'(err_underflow), 32'd1);
    chk("unf_pop_depth", 32'(depth_out), 32'd0);
    chk("unf_pop_ready", 32'(op_ready), 32'd1);
    op(3'd1, 8'h11, 1'b0);
    op(3'd3, 8'hAA, 1'b1);
    chk("unf_binop_flag", 32'(err_underflow), 32'd1);
    chk_stack("unf_binop", 8'h11, 8'h00, 3'd1);
    op(3'd5, 8'h00, 1'b1);
    chk("unf_swap_flag", 32'(err_underflow), 32'd1);
    idle(1'b1);
    chk("unf_clear", 32'(err_underflow), 32'd0);

    // BINOP with refill, then SWAP
    op(3'd1, 8'h22, 1'b0);
    op(3'd1, 8'h33, 1'b0);
    op(3'd3, 8'h99, 1'b0);
    chk("binop_tos", 32'(tos_out), 32'h99);
    chk("binop_ready", 32'(op_ready), 32'd0);
    idle(1'b0);
    chk_stack("binop", 8'h99, 8'h11, 3'd2);
    op(3'd5, 8'h00, 1'b0);
    chk_stack("swap", 8'h11, 8'h99, 3'd2);

    // DUP, REPL, NOP, reserved
    op(3'd4, 8'h00, 1'b0);
    chk_stack("dup", 8'h11, 8'h11, 3'd3);
    op(3'd6, 8'h77, 1'b0);
    chk_stack("repl", 8'h77, 8'h11, 3'd3);
    op(3'd0, 8'hEE, 1'b0);
    chk_stack("nop", 8'h77, 8'h11, 3'd3);
    op(3'd7, 8'hEE, 1'b0);
    chk_stack("rsvd", 8'h77, 8'h11, 3'd3);
    chk("rsvd_errs", 32'({err_overflow, err_underflow}), 32'd0);

    // Reset during refill
    op(3'd2, 8'h00, 1'b0);
    chk("rr_refill_ready", 32'(op_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_stack("rr_rst", 8'h00, 8'h00, 3'd0);
    chk("rr_rst_ready", 32'(op_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr_release_ready", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rr_idle_ready", 32'(op_ready), 32'd1);
    op(3'd1, 8'h5A, 1'b0);
    chk_stack("rr_push", 8'h5A, 8'h00, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
